sd_cmd_ctrl: RTL and testbench

//  Sequencer for the SD CMD line. Generates SDCLK, serialises a 48-bit command (start bit,

---
 rtl/sd_cmd_ctrl.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_sd_cmd_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_ctrl.sv
// ----------------------------------------------------------------------------
// sd_cmd_ctrl
//   Sequencer for the SD CMD line. Divides clk_i down to SDCLK, serialises a
//   48-bit command frame with a serially computed CRC7, waits for the card's
//   response start bit, shifts the response in (48 or 136 bits), checks the
//   CRC7 of 48-bit R1-type responses and reports timeout / CRC status.
//
//   Optional feature macro: SD_CMD_PWRUP_CLK_EN
//     defined   : after reset the FSM runs SDCLK for 74 cycles with CMD
//                 released (PWRUP) before entering IDLE.
//     undefined : reset lands directly in IDLE.
//
//   Handshake: a command is accepted on a clk_i edge where cmd_valid_i and
//   cmd_ready_o are both 1. cmd_ready_o is 1 only while idle and drops the
//   cycle after an accept; cmd_valid_i is ignored otherwise. rsp_valid_o is a
//   single-cycle pulse with no back-pressure; status/data are held until the
//   next response is reported.
//
// Ports
//   clk_i, rst_i           system clock, asynchronous active-high reset
//   cmd_valid_i/ready_o    command request handshake
//   cmd_index_i, cmd_arg_i command index (6b) and argument (32b)
//   rsp_type_i             00 none, 01 48b+CRC, 10 136b, 11 48b no CRC
//   rsp_valid_o            transaction finished pulse
//   rsp_data_o             48b: {88'b0, bits[47:8]}; 136b: bits[127:0]
//   rsp_crc_err_o          CRC7 mismatch (type 01 only)
//   rsp_timeout_o          no response start bit in time
//   sdclk_o                SD clock pad
//   cmd_o, cmd_oe_o, cmd_i CMD pad output, output enable, input
// ----------------------------------------------------------------------------
module sd_cmd_ctrl #(
    parameter int CLK_DIV     = 400,
    parameter int RSP_TIMEOUT = 64,
    parameter int NCC_CYCLES  = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    input  logic [5:0]   cmd_index_i,
    input  logic [31:0]  cmd_arg_i,
    input  logic [1:0]   rsp_type_i,
    output logic         rsp_valid_o,
    output logic [127:0] rsp_data_o,
    output logic         rsp_crc_err_o,
    output logic         rsp_timeout_o,
    output logic         sdclk_o,
    output logic         cmd_o,
    output logic         cmd_oe_o,
    input  logic         cmd_i
);

    localparam int HALF = CLK_DIV / 2;
    localparam int DW   = $clog2(HALF + 1);
    localparam int TW   = $clog2(RSP_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SEND, S_WAIT, S_RECV, S_NCC, S_PWRUP
    } state_t;

`ifdef SD_CMD_PWRUP_CLK_EN
    localparam state_t RST_STATE = S_PWRUP;
    localparam logic [7:0] PWRUP_RISES = 8'd74;
`else
    localparam state_t RST_STATE = S_IDLE;
`endif

    state_t          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic            sdclk_q, sdclk_d;
    logic [39:0]     tx_q, tx_d;
    logic [6:0]      crc_q, crc_d;
    logic [1:0]      type_q, type_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic [127:0]    rx_q, rx_d;
    logic [6:0]      rx_crc_q, rx_crc_d;
    logic            crc_err_q, crc_err_d;
    logic            to_err_q, to_err_d;
    logic            cmd_q, cmd_d;
    logic            oe_q, oe_d;
    logic            ready_q, ready_d;
    logic            valid_q, valid_d;
    logic [127:0]    data_o_q, data_o_d;
    logic            crc_o_q, crc_o_d;
    logic            to_o_q, to_o_d;

    logic            clk_run, tick, rise_stb, fall_stb, accept;
    logic [7:0]      rx_last;
    logic [127:0]    rx_shift;

    // One serial CRC7 step, polynomial x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    endfunction

    // SDCLK runs in every state except IDLE. The strobes mark the clk_i edge
    // on which sdclk_o rises or falls.
    assign clk_run  = (state_q != S_IDLE);
    assign tick     = clk_run && (div_q == DW'(HALF - 1));
    assign rise_stb = tick && !sdclk_q;
    assign fall_stb = tick && sdclk_q;
    // ready_q guards the first cycle after reset, when state is already IDLE.
    assign accept   = (state_q == S_IDLE) && cmd_valid_i && ready_q;
    // Index of the last response bit; the start bit is bit count 0.
    assign rx_last  = (type_q == 2'b10) ? 8'd135 : 8'd47;
    assign rx_shift = {rx_q[126:0], cmd_i};

    // State and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= RST_STATE;
            div_q     <= '0;
            sdclk_q   <= 1'b0;
            tx_q      <= '0;
            crc_q     <= '0;
            type_q    <= '0;
            cnt_q     <= '0;
            to_cnt_q  <= '0;
            rx_q      <= '0;
            rx_crc_q  <= '0;
            crc_err_q <= 1'b0;
            to_err_q  <= 1'b0;
            cmd_q     <= 1'b1;
            oe_q      <= 1'b0;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            data_o_q  <= '0;
            crc_o_q   <= 1'b0;
            to_o_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            sdclk_q   <= sdclk_d;
            tx_q      <= tx_d;
            crc_q     <= crc_d;
            type_q    <= type_d;
            cnt_q     <= cnt_d;
            to_cnt_q  <= to_cnt_d;
            rx_q      <= rx_d;
            rx_crc_q  <= rx_crc_d;
            crc_err_q <= crc_err_d;
            to_err_q  <= to_err_d;
            cmd_q     <= cmd_d;
            oe_q      <= oe_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            data_o_q  <= data_o_d;
            crc_o_q   <= crc_o_d;
            to_o_q    <= to_o_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_SEND;
            S_SEND: if (fall_stb && cnt_q == 8'd48)
                        state_d = (type_q == 2'b00) ? S_NCC : S_WAIT;
            S_WAIT: if (rise_stb) begin
                        if (!cmd_i)
                            state_d = S_RECV;
                        else if (to_cnt_q == TW'(RSP_TIMEOUT - 1))
                            state_d = S_NCC;
                    end
            S_RECV: if (rise_stb && cnt_q == rx_last) state_d = S_NCC;
            S_NCC:  if (fall_stb && cnt_q == 8'(NCC_CYCLES - 1)) state_d = S_IDLE;
`ifdef SD_CMD_PWRUP_CLK_EN
            // Leave on the fall that completes the 74th cycle so SDCLK stops low.
            S_PWRUP: if (fall_stb && cnt_q == PWRUP_RISES) state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: divider, serialiser, deserialiser, counters.
    always_comb begin
        div_d     = div_q;
        sdclk_d   = sdclk_q;
        tx_d      = tx_q;
        crc_d     = crc_q;
        type_d    = type_q;
        cnt_d     = cnt_q;
        to_cnt_d  = to_cnt_q;
        rx_d      = rx_q;
        rx_crc_d  = rx_crc_q;
        crc_err_d = crc_err_q;
        to_err_d  = to_err_q;
        cmd_d     = cmd_q;
        oe_d      = oe_q;

        if (!clk_run) begin
            div_d   = '0;
            sdclk_d = 1'b0;
        end else if (tick) begin
            div_d   = '0;
            sdclk_d = ~sdclk_q;
        end else begin
            div_d   = div_q + 1'b1;
        end

        case (state_q)
            S_IDLE: if (accept) begin
                tx_d      = {2'b01, cmd_index_i, cmd_arg_i};
                type_d    = rsp_type_i;
                crc_d     = '0;
                cnt_d     = '0;
                to_cnt_d  = '0;
                rx_d      = '0;
                rx_crc_d  = '0;
                crc_err_d = 1'b0;
                to_err_d  = 1'b0;
            end
            // cnt_q = number of bits already driven; count 48 is the release fall.
            S_SEND: if (fall_stb) begin
                cnt_d = cnt_q + 8'd1;
                cmd_d = 1'b1;
                oe_d  = 1'b1;
                if (cnt_q < 8'd40) begin
                    cmd_d = tx_q[39];
                    tx_d  = {tx_q[38:0], 1'b0};
                    crc_d = crc7_step(crc_q, tx_q[39]);
                end else if (cnt_q < 8'd47) begin
                    cmd_d = crc_q[6];
                    crc_d = {crc_q[5:0], 1'b0};
                end else if (cnt_q == 8'd48) begin
                    oe_d  = 1'b0;
                    cnt_d = '0;
                end
            end
            S_WAIT: if (rise_stb) begin
                if (!cmd_i) begin
                    rx_d     = rx_shift;
                    rx_crc_d = crc7_step(rx_crc_q, cmd_i);
                    cnt_d    = 8'd1;
                end else if (to_cnt_q == TW'(RSP_TIMEOUT - 1)) begin
                    to_err_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_RECV: if (rise_stb) begin
                rx_d  = rx_shift;
                cnt_d = cnt_q + 8'd1;
                if (cnt_q < 8'd40)
                    rx_crc_d = crc7_step(rx_crc_q, cmd_i);
                if (cnt_q == rx_last) begin
                    cnt_d     = '0;
                    crc_err_d = (type_q == 2'b01) && (rx_crc_q != rx_shift[7:1]);
                end
            end
            S_NCC: if (fall_stb) cnt_d = cnt_q + 8'd1;
`ifdef SD_CMD_PWRUP_CLK_EN
            S_PWRUP: if (rise_stb) cnt_d = cnt_q + 8'd1;
`endif
            default: ;
        endcase
    end

    // Registered handshake/status outputs, decoded from the next state.
    always_comb begin
        ready_d  = (state_d == S_IDLE);
        valid_d  = (state_q == S_NCC) && (state_d == S_IDLE);
        data_o_d = data_o_q;
        crc_o_d  = crc_o_q;
        to_o_d   = to_o_q;
        if (valid_d) begin
            data_o_d = (type_q == 2'b10) ? rx_q : {88'b0, rx_q[47:8]};
            crc_o_d  = crc_err_q;
            to_o_d   = to_err_q;
        end
    end

    assign cmd_ready_o   = ready_q;
    assign rsp_valid_o   = valid_q;
    assign rsp_data_o    = data_o_q;
    assign rsp_crc_err_o = crc_o_q;
    assign rsp_timeout_o = to_o_q;
    assign sdclk_o       = sdclk_q;
    assign cmd_o         = cmd_q;
    assign cmd_oe_o      = oe_q;

endmodule

// File: tb/tb_sd_cmd_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sd_cmd_ctrl
//   Directed vector table plus randomized transactions for sd_cmd_ctrl, with a
//   card model that drives CMD responses and a reference model that derives
//   frames and CRCs by polynomial division.
// ----------------------------------------------------------------------------
module tb_sd_cmd_ctrl;

    localparam int CLK_DIV     = 4;
    localparam int RSP_TIMEOUT = 64;
    localparam int NCC_CYCLES  = 8;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid_i = 1'b0;
    logic         cmd_ready_o;
    logic [5:0]   cmd_index_i = '0;
    logic [31:0]  cmd_arg_i = '0;
    logic [1:0]   rsp_type_i = '0;
    logic         rsp_valid_o;
    logic [127:0] rsp_data_o;
    logic         rsp_crc_err_o;
    logic         rsp_timeout_o;
    logic         sdclk_o;
    logic         cmd_o;
    logic         cmd_oe_o;
    logic         cmd_i = 1'b1;

    always #5 clk = ~clk;

    sd_cmd_ctrl #(
        .CLK_DIV(CLK_DIV), .RSP_TIMEOUT(RSP_TIMEOUT), .NCC_CYCLES(NCC_CYCLES)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_index_i(cmd_index_i), .cmd_arg_i(cmd_arg_i), .rsp_type_i(rsp_type_i),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
        .rsp_crc_err_o(rsp_crc_err_o), .rsp_timeout_o(rsp_timeout_o),
        .sdclk_o(sdclk_o), .cmd_o(cmd_o), .cmd_oe_o(cmd_oe_o), .cmd_i(cmd_i)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    int txn_id = 0;
    // {check_data, crc_err, timeout, data[127:0]}
    logic [130:0] exp_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL txn%0d %s: got 0x%0h, expected 0x%0h", txn_id, name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        checks++;
        errors++;
        $display("FAIL txn%0d %s: wait bound expired", txn_id, name);
    endtask

    // ---------------- reference model ----------------
    // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
    function automatic logic [6:0] crc7(input logic [39:0] m);
        logic [46:0] r;
        r = {m, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r = r ^ (47'h89 << (i - 7));
        return r[6:0];
    endfunction

    function automatic logic [47:0] frame48(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] body;
        body = {2'b01, idx, arg};
        return {body, crc7(body), 1'b1};
    endfunction

    // ---------------- driver helpers ----------------
    // Advance clk_i until sdclk_o shows the requested transition; sampled 1 time
    // unit after each active edge.
    task automatic wait_edge(input bit rise, output bit ok);
        logic prev;
        ok = 1'b0;
        prev = sdclk_o;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (rise ? (!prev && sdclk_o) : (prev && !sdclk_o)) begin
                ok = 1'b1;
                return;
            end
            prev = sdclk_o;
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready_o) begin
                ok = 1'b1;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] typ);
        cmd_index_i = idx;
        cmd_arg_i   = arg;
        rsp_type_i  = typ;
        cmd_valid_i = 1'b1;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        // Scramble inputs to show the command was latched at accept.
        cmd_index_i = 6'($urandom_range(0, 63));
        cmd_arg_i   = $urandom;
        rsp_type_i  = 2'($urandom_range(0, 3));
        check("ready_drop", cmd_ready_o, 0);
    endtask

    task automatic post_reset_ready();
`ifdef SD_CMD_PWRUP_CLK_EN
        int rises;
        logic prev;
        bit ok;
        rises = 0;
        ok = 1'b0;
        prev = sdclk_o;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (!prev && sdclk_o) rises++;
            prev = sdclk_o;
            if (cmd_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_bound("pwrup_ready");
        else check("pwrup_rises", rises, 74);
`else
        @(posedge clk); #1;
        check("ready_after_reset", cmd_ready_o, 1);
`endif
    endtask

    // One complete transaction: send, card reply, response check.
    task automatic run_txn(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] typ,
                           input bit no_reply, input int dly, input logic [135:0] reply,
                           input int nbits, input logic [47:0] exp_frame,
                           input logic [130:0] exp_entry);
        bit ok, got, oe_bad;
        logic [47:0] sent;
        logic [130:0] e;
        logic prev;
        int rises, falls;
        txn_id++;
        wait_ready(ok);
        if (!ok) begin fail_bound("ready_wait"); return; end
        issue(idx, arg, typ);
        wait_edge(1'b0, ok);
        if (!ok) begin fail_bound("first_fall"); return; end
        oe_bad = 1'b0;
        for (int b = 47; b >= 0; b--) begin
            wait_edge(1'b1, ok);
            if (!ok) begin fail_bound("bit_rise"); return; end
            sent[b] = cmd_o;
            if (!cmd_oe_o) oe_bad = 1'b1;
        end
        check("frame", sent, exp_frame);
        check("oe_in_frame", oe_bad, 0);
        wait_edge(1'b0, ok);
        if (!ok) begin fail_bound("release_fall"); return; end
        check("release", {cmd_oe_o, cmd_o}, 2'b01);

        // Card model: reply changes on SDCLK falls.
        if (typ != 2'b00 && !no_reply) begin
            for (int d = 0; d < dly; d++) wait_edge(1'b0, ok);
            for (int b = nbits - 1; b >= 0; b--) begin
                cmd_i = reply[b];
                wait_edge(1'b0, ok);
            end
            cmd_i = 1'b1;
        end

        exp_q.push_back(exp_entry);
        got = 1'b0;
        rises = 0;
        falls = 0;
        prev = sdclk_o;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (prev && !sdclk_o) falls++;
            if (!prev && sdclk_o) rises++;
            prev = sdclk_o;
            if (rsp_valid_o) begin got = 1'b1; break; end
        end
        e = exp_q.pop_front();
        if (!got) begin fail_bound("rsp_valid"); return; end
        check("crc_err", rsp_crc_err_o, e[129]);
        check("timeout", rsp_timeout_o, e[128]);
        if (e[130]) check("rsp_data", rsp_data_o, e[127:0]);
        check("ready_at_valid", cmd_ready_o, 1);
        if (typ == 2'b00) check("ncc_falls", falls, NCC_CYCLES);
        if (e[128])
            check("timeout_rises",
                  (rises >= RSP_TIMEOUT + NCC_CYCLES - 1) && (rises <= RSP_TIMEOUT + NCC_CYCLES), 1);
        @(posedge clk); #1;
        check("valid_pulse", rsp_valid_o, 0);
        check("sdclk_idle_low", sdclk_o, 0);
        if (e[130]) check("data_hold", rsp_data_o, e[127:0]);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [1:0]  typ;
        bit          no_reply;
        int          dly;
        bit          has_frame;
        logic [47:0] frame;
        logic [47:0] reply;
        bit          exp_crc;
        bit          exp_to;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] payload;
        logic [135:0] reply;
        logic [130:0] ent;
        logic [39:0]  body;
        logic [6:0]   crcv;
        logic [5:0]   idx;
        logic [31:0]  arg;
        logic [1:0]   typ;
        bit           nr, ok;
        int           dly, nbits, vcount;

        vecs[0] = '{6'd0,  32'h0000_0000, 2'b00, 1'b1, 0, 1'b1, 48'h40_0000_0000_95, 48'h0, 1'b0, 1'b0};
        vecs[1] = '{6'd8,  32'h0000_01AA, 2'b01, 1'b0, 5, 1'b1, 48'h48_0000_01AA_87, 48'h08_0000_01AA_13, 1'b0, 1'b0};
        vecs[2] = '{6'd8,  32'h0000_01AA, 2'b01, 1'b0, 5, 1'b1, 48'h48_0000_01AA_87, 48'h08_0000_01AA_11, 1'b1, 1'b0};
        vecs[3] = '{6'd55, 32'h0000_0000, 2'b01, 1'b1, 0, 1'b0, 48'h0, 48'h0, 1'b0, 1'b1};
        vecs[4] = '{6'd2,  32'h0000_0000, 2'b10, 1'b0, 3, 1'b0, 48'h0, 48'h0, 1'b0, 1'b0};
        vecs[5] = '{6'd41, 32'h40FF_8000, 2'b11, 1'b0, 7, 1'b0, 48'h0, 48'h3F_80FF_8000_FF, 1'b0, 1'b0};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_sdclk", sdclk_o, 0);
        check("rst_cmd", cmd_o, 1);
        check("rst_oe", cmd_oe_o, 0);
        check("rst_ready", cmd_ready_o, 0);
        check("rst_valid", rsp_valid_o, 0);
        check("rst_data", rsp_data_o, 0);
        check("rst_flags", {rsp_crc_err_o, rsp_timeout_o}, 0);
        rst = 1'b0;
        post_reset_ready();

        // Directed table.
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].typ == 2'b10) begin
                payload = {$urandom, $urandom, $urandom, $urandom};
                payload[0] = 1'b1;
                reply = {2'b00, 6'h3F, payload};
                nbits = 136;
            end else begin
                payload = {88'b0, vecs[v].reply[47:8]};
                reply = {88'b0, vecs[v].reply};
                nbits = 48;
            end
            ent = {(vecs[v].typ != 2'b00) && !vecs[v].no_reply, vecs[v].exp_crc, vecs[v].exp_to, payload};
            run_txn(vecs[v].idx, vecs[v].arg, vecs[v].typ, vecs[v].no_reply, vecs[v].dly, reply, nbits,
                    vecs[v].has_frame ? vecs[v].frame : frame48(vecs[v].idx, vecs[v].arg), ent);
        end

        // Randomized transactions against the reference model.
        for (int r = 0; r < 14; r++) begin
            typ = 2'($urandom_range(0, 3));
            idx = 6'($urandom_range(0, 63));
            arg = $urandom;
            nr  = (typ != 2'b00) && ($urandom_range(0, 5) == 0);
            dly = $urandom_range(0, 30);
            if (typ == 2'b10) begin
                payload = {$urandom, $urandom, $urandom, $urandom};
                payload[0] = 1'b1;
                reply = {2'b00, 6'h3F, payload};
                nbits = 136;
            end else begin
                body = {2'b00, (typ == 2'b11) ? 6'h3F : idx, $urandom};
                crcv = (typ == 2'b11) ? 7'h7F : crc7(body);
                if (typ == 2'b01 && $urandom_range(0, 3) == 0) crcv = crcv ^ 7'h01;
                reply = {88'b0, body, crcv, 1'b1};
                payload = {88'b0, body};
                nbits = 48;
            end
            ent = {(typ != 2'b00) && !nr,
                   !nr && (typ == 2'b01) && (reply[7:1] != crc7(reply[47:8])),
                   nr, payload};
            run_txn(idx, arg, typ, nr, dly, reply, nbits, frame48(idx, arg), ent);
        end

        // Reset mid-SEND at bit 20: abort, no response, recovery.
        txn_id++;
        wait_ready(ok);
        if (!ok) fail_bound("ready_wait");
        else begin
            issue(6'd17, 32'h1234_5678, 2'b01);
            wait_edge(1'b0, ok);
            for (int b = 47; b >= 20; b--) wait_edge(1'b1, ok);
            #2 rst = 1'b1;
            #1;
            check("abort_oe", cmd_oe_o, 0);
            check("abort_sdclk", sdclk_o, 0);
            check("abort_cmd", cmd_o, 1);
            check("abort_ready", cmd_ready_o, 0);
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;
            post_reset_ready();
            vcount = 0;
            for (int i = 0; i < 600; i++) begin
                @(posedge clk); #1;
                if (rsp_valid_o) vcount++;
            end
            check("abort_no_valid", vcount, 0);
        end

        // Normal command after the abort.
        run_txn(6'd8, 32'h0000_01AA, 2'b01, 1'b0, 2, {88'b0, 48'h08_0000_01AA_13}, 48,
                48'h48_0000_01AA_87, {1'b1, 1'b0, 1'b0, 88'b0, 40'h08_0000_01AA});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
